// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction word format, the "no instruction"
// encoding presented on an empty pipeline slot, and the fetch FSM encoding.
package cpu_pkg;
    localparam int                 INSTR_W   = 16;
    localparam logic [3:0]         OPC_NONE  = 4'b1111;
    localparam logic [INSTR_W-1:0] NOP_INSTR = {OPC_NONE, 12'h000};

    localparam logic [0:0] FS_IDLE = 1'b0;
    localparam logic [0:0] FS_WAIT = 1'b1;

    function automatic logic [3:0] opcodeOf(input logic [INSTR_W-1:0] instr);
        return instr[INSTR_W-1:INSTR_W-4];
    endfunction
endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO between the fetch logic and the IF/ID outputs; slot 0 is
// always the head, so a pop shifts slot 1 forward.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int DATA_W = 24
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] pushData_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [1:0]        count_o
);
    logic [DATA_W-1:0] slot0_q, slot0_d, slot1_q, slot1_d;
    logic [1:0]        count_q, count_d, occAfterPop;
    logic              doPop, doPush;

    // Pop happens before push, so a simultaneous push/pop on a full queue is legal.
    always_comb begin
        slot0_d     = slot0_q;
        slot1_d     = slot1_q;
        count_d     = count_q;
        doPop       = pop_i && (count_q != 2'd0);
        doPush      = push_i && ((count_q != 2'd2) || doPop);
        occAfterPop = count_q - {1'b0, doPop};
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            if (doPop) begin
                slot0_d = slot1_q;
            end
            if (doPush) begin
                if (occAfterPop == 2'd0) begin
                    slot0_d = pushData_i;
                end else begin
                    slot1_d = pushData_i;
                end
            end
            count_d = count_q + {1'b0, doPush} - {1'b0, doPop};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
        end
    end

    assign head_o  = slot0_q;
    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign count_o = count_q;
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: at most one instruction-memory read in flight,
// responses tagged with an epoch so reads made before a redirect are dropped.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_run,
    input  logic               i_stall,
    input  logic               i_branch_taken,
    input  logic [ADDR_W-1:0]  i_branch_target,
    output logic               o_imem_req,
    output logic [ADDR_W-1:0]  o_imem_addr,
    input  logic               i_imem_rvalid,
    input  logic [INSTR_W-1:0] i_imem_rdata,
    output logic               o_valid,
    output logic [INSTR_W-1:0] o_instr,
    output logic [ADDR_W-1:0]  o_pc
);
    localparam int ENTRY_W = ADDR_W + INSTR_W;

    logic [0:0]         state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d, reqPc_q, reqPc_d, outPc_q;
    logic               epoch_q, epoch_d, reqEpoch_q, reqEpoch_d;

    logic [ENTRY_W-1:0] qHead;
    logic               qFull, qEmpty;
    logic [1:0]         qCount;
    logic               rspDone, push, pop, issue;
    logic [2:0]         occNext;

    // Room is judged on occupancy after this cycle's pop and push, which
    // guarantees the slot is still free whenever the response comes back.
    always_comb begin
        rspDone = (state_q == FS_WAIT) && i_imem_rvalid;
        pop     = !qEmpty && !i_stall && !i_branch_taken && !i_rst;
        push    = rspDone && (reqEpoch_q == epoch_q) && !i_branch_taken && !i_rst
                  && (!qFull || pop);
        occNext = {1'b0, qCount} + {2'b0, push} - {2'b0, pop};
        issue   = !i_rst && !i_branch_taken && i_run && (occNext < 3'd2)
                  && ((state_q == FS_IDLE) || rspDone);
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        epoch_d    = epoch_q;
        reqPc_d    = reqPc_q;
        reqEpoch_d = reqEpoch_q;
        if (i_branch_taken) begin
            pc_d    = i_branch_target;
            epoch_d = ~epoch_q;
            if (rspDone) begin
                state_d = FS_IDLE;
            end
        end else if (issue) begin
            state_d    = FS_WAIT;
            pc_d       = pc_q + 1'b1;
            reqPc_d    = pc_q;
            reqEpoch_d = epoch_q;
        end else if (rspDone) begin
            state_d = FS_IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= FS_IDLE;
            pc_q       <= RESET_PC;
            epoch_q    <= 1'b0;
            reqPc_q    <= '0;
            reqEpoch_q <= 1'b0;
            outPc_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            epoch_q    <= epoch_d;
            reqPc_q    <= reqPc_d;
            reqEpoch_q <= reqEpoch_d;
            if (!qEmpty) begin
                outPc_q <= qHead[ENTRY_W-1:INSTR_W];
            end
        end
    end

    fetch_queue #(
        .DATA_W(ENTRY_W)
    ) u_queue (
        .clk_i      (i_clk),
        .rst_i      (i_rst),
        .flush_i    (i_branch_taken),
        .push_i     (push),
        .pushData_i ({reqPc_q, i_imem_rdata}),
        .pop_i      (pop),
        .head_o     (qHead),
        .full_o     (qFull),
        .empty_o    (qEmpty),
        .count_o    (qCount)
    );

    // An empty slot shows the NONE opcode and keeps the last displayed PC.
    assign o_imem_req  = issue;
    assign o_imem_addr = issue ? pc_q : '0;
    assign o_valid     = !qEmpty;
    assign o_instr     = qEmpty ? NOP_INSTR : qHead[INSTR_W-1:0];
    assign o_pc        = qEmpty ? outPc_q : qHead[ENTRY_W-1:INSTR_W];
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: ADDR_W, default 8, instruction-memory word-address width.
REQ-002 Parameter: RESET_PC, default 0, first fetch address after reset.
REQ-003 i_clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 i_rst  input  1  reset; synchronous, active-high.
REQ-005 i_run  input  1  fetch enable; held low by the UART loader until the program is loaded.
REQ-006 i_stall  input  1  downstream hazard stall; hold the current IF/ID output.
REQ-007 i_branch_taken  input  1  resolved taken branch; redirect fetch.
REQ-008 i_branch_target  input  ADDR_W  redirect address.
REQ-009 o_imem_req  output  1  one-cycle read request pulse.
REQ-010 o_imem_addr  output  ADDR_W  read address, valid while o_imem_req is high.
REQ-011 i_imem_rvalid  input  1  read data valid; latency of 1 or more cycles after the request.
REQ-012 i_imem_rdata  input  16  instruction word; opcode in bits [15:12].
REQ-013 o_valid  output  1  IF/ID holds a real instruction.
REQ-014 o_instr  output  16  IF/ID instruction; opcode bits feed the opcode decoder.
REQ-015 o_pc  output  ADDR_W  address of o_instr.

Function
REQ-016 State machine SHALL have two states: IDLE (no read outstanding) and WAIT (one read outstanding); at most one request SHALL be outstanding.
REQ-017 Room SHALL be defined as: 2-entry queue occupancy after this cycle's pop and push is below 2.
REQ-018 In IDLE with i_run=1, room, and no redirect, the block SHALL pulse o_imem_req with o_imem_addr=PC, set PC to PC+1 and enter WAIT.
REQ-019 In WAIT with i_imem_rvalid=1 and a matching epoch, the block SHALL push {PC of request, i_imem_rdata} into the queue.
REQ-020 In WAIT with i_imem_rvalid=1, the block SHALL issue the next request in the same cycle if i_run=1 and there is room; otherwise it SHALL return to IDLE.
REQ-021 PC arithmetic SHALL be modulo 2^ADDR_W; address 2^ADDR_W-1 SHALL wrap to 0.
REQ-022 Outputs SHALL present the queue head: o_valid=1 when the queue is non-empty; otherwise o_valid=0, o_instr=16'hF000 (opcode NONE) and o_pc unchanged.
REQ-023 The head SHALL pop when o_valid=1 and i_stall=0; when i_stall=1 the outputs SHALL hold.
REQ-024 A push and a pop in the same cycle SHALL leave occupancy unchanged; a push to a full queue SHALL never occur.
REQ-025 On i_branch_taken=1 the block SHALL clear the queue, load PC with i_branch_target and toggle a 1-bit epoch; the next cycle SHALL show o_valid=0 and o_instr=16'hF000.
REQ-026 Redirect SHALL take priority over stall, push, pop and request issue in the same cycle.
REQ-027 A response whose epoch differs from the current epoch SHALL be discarded but SHALL still end the outstanding request.
REQ-028 When i_run falls, no new request SHALL be issued; an outstanding read SHALL complete, and the queue SHALL keep draining.
REQ-029 With 1-cycle memory and no stall, sustained throughput SHALL be one instruction per cycle; the first o_valid SHALL appear 2 cycles after the first request.

Reset
REQ-030 Reset SHALL take effect on the clock edge and SHALL override all other inputs.
REQ-031 After reset: PC=RESET_PC, state IDLE, queue empty, epoch 0, o_imem_req=0, o_imem_addr=0, o_valid=0, o_instr=16'hF000, o_pc=0.
REQ-032 A response arriving after reset mid-read SHALL be ignored; the epoch SHALL reset and state SHALL be IDLE.

Structure
REQ-033 Shared package cpu_pkg SHALL hold INSTR_W=16, OPC_NONE=4'b1111, NOP_INSTR=16'hF000 and the fetch state encoding.
REQ-034 The 2-entry queue SHALL be the sub-module fetch_queue, with push, pop, flush, full, empty and count.

Verification
REQ-035 Reset, i_run=1, 1-cycle memory returning word=addr|16'h2000 -> o_pc sequence 0,1,2,... with one instruction per cycle, and first o_valid 2 cycles after the first request.
REQ-036 i_stall=1 for 3 cycles at o_pc=4 -> o_instr holds, queue fills to 2, o_imem_req stays low while full, and no instruction is lost or duplicated.
REQ-037 i_branch_taken=1 with target 8'h40 while a read is outstanding -> stale response dropped, next cycle o_valid=0/o_instr=16'hF000, then o_pc=8'h40.
REQ-038 Redirect and stall in the same cycle -> redirect wins and the queue is empty the next cycle.
REQ-039 PC=8'hFF with ADDR_W=8 -> next o_imem_addr=8'h00.
REQ-040 Reset asserted in WAIT, rvalid the next cycle -> response ignored and all outputs at their reset values.
